// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with start/done handshake, latched carry, add-with-carry and tri-state result.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier for op 101.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_nReset,
    input  logic             i_start,
    input  logic [2:0]       i_aluOp,
    input  logic             i_sub,
    input  logic             i_shiftLeft,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bWr,
    input  logic             i_oe,
    output logic [WIDTH-1:0] o_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_negative,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_overflow
);
    localparam int SHIFT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SHF  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_ADC  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, MUL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

    state_t           state_r, state_s;
    logic [WIDTH-1:0] b_r, b_s;
    logic [WIDTH-1:0] y_r, y_s;
    logic             n_r, n_s, z_r, z_s, c_r, c_s, v_r, v_s;
    logic             done_r, done_s;
    logic             b_locked_s;

    logic [WIDTH-1:0] sb_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH:0]   shr_s;
    logic [SHIFT_W-1:0] amt_s;
    logic [WIDTH-1:0] alu_y_s;
    logic             alu_c_s, alu_v_s;

`ifdef ALU_MUL_EN
    logic                 busy_r, busy_s;
    logic [2*WIDTH-1:0]   mcand_r, mcand_s;
    logic [2*WIDTH-1:0]   acc_r, acc_s, acc_sum_s;
    logic [WIDTH-1:0]     mplier_r, mplier_s;
    logic [SHIFT_W-1:0]   cnt_r, cnt_s;

    assign acc_sum_s  = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    assign b_locked_s = busy_r;
    assign o_busy     = busy_r;
`else
    assign b_locked_s = 1'b0;
    assign o_busy     = 1'b0;
`endif

    // Adder input: op 110 chains the latched carry, op 000 uses i_sub as the +1 of two's complement.
    assign sb_s  = b_r ^ {WIDTH{i_sub}};
    assign cin_s = (i_aluOp == OP_ADC) ? c_r : i_sub;
    assign sum_s = {1'b0, i_a} + {1'b0, sb_s} + {{WIDTH{1'b0}}, cin_s};
    assign amt_s = b_r[SHIFT_W-1:0];
    // The extra bit beyond the data catches the last bit shifted out (0 when the amount is 0).
    assign shl_s = {1'b0, i_a} << amt_s;
    assign shr_s = {i_a, 1'b0} >> amt_s;

    // Single-cycle result, carry and overflow for the current opcode
    always_comb begin
        alu_y_s = {WIDTH{1'b0}};
        alu_c_s = 1'b0;
        alu_v_s = 1'b0;
        case (i_aluOp)
            OP_ADD, OP_ADC: begin
                alu_y_s = sum_s[WIDTH-1:0];
                alu_c_s = sum_s[WIDTH];
                alu_v_s = (i_a[WIDTH-1] == sb_s[WIDTH-1]) && (sum_s[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  alu_y_s = i_a & b_r;
            OP_XOR:  alu_y_s = i_a ^ b_r;
            OP_OR:   alu_y_s = i_a | b_r;
            OP_PASS: alu_y_s = b_r;
            OP_SHF: begin
                if (i_shiftLeft) begin
                    alu_y_s = shl_s[WIDTH-1:0];
                    alu_c_s = shl_s[WIDTH];
                end else begin
                    alu_y_s = shr_s[WIDTH:1];
                    alu_c_s = shr_s[0];
                end
            end
            OP_MUL:  alu_y_s = {WIDTH{1'b0}};
            default: alu_y_s = {WIDTH{1'b0}};
        endcase
    end

    // Next state, B register, result/flag registers and handshake
    always_comb begin
        state_s = state_r;
        y_s     = y_r;
        n_s     = n_r;
        z_s     = z_r;
        c_s     = c_r;
        v_s     = v_r;
        done_s  = 1'b0;
`ifdef ALU_MUL_EN
        busy_s   = 1'b0;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
`endif
        if (i_bWr && !b_locked_s) begin
            b_s = i_b;
        end else begin
            b_s = b_r;
        end
        case (state_r)
            IDLE, DONE: begin
`ifdef ALU_MUL_EN
                if (i_start && (i_aluOp == OP_MUL)) begin
                    state_s  = MUL;
                    busy_s   = 1'b1;
                    mcand_s  = {{WIDTH{1'b0}}, i_a};
                    mplier_s = b_r;
                    acc_s    = {(2*WIDTH){1'b0}};
                    cnt_s    = {SHIFT_W{1'b0}};
                end else if (i_start) begin
`else
                if (i_start) begin
`endif
                    state_s = DONE;
                    y_s     = alu_y_s;
                    n_s     = alu_y_s[WIDTH-1];
                    z_s     = (alu_y_s == {WIDTH{1'b0}});
                    c_s     = alu_c_s;
                    v_s     = alu_v_s;
                    done_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
`ifdef ALU_MUL_EN
            MUL: begin
                acc_s    = acc_sum_s;
                mcand_s  = mcand_r << 1'b1;
                mplier_s = mplier_r >> 1'b1;
                if (cnt_r == SHIFT_W'(WIDTH - 1)) begin
                    state_s = DONE;
                    y_s     = acc_sum_s[WIDTH-1:0];
                    n_s     = acc_sum_s[WIDTH-1];
                    z_s     = (acc_sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    c_s     = |acc_sum_s[2*WIDTH-1:WIDTH];
                    v_s     = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s  = cnt_r + {{(SHIFT_W-1){1'b0}}, 1'b1};
                    busy_s = 1'b1;
                end
            end
`endif
            default: state_s = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state_r  <= IDLE;
            b_r      <= {WIDTH{1'b0}};
            y_r      <= {WIDTH{1'b0}};
            n_r      <= 1'b0;
            z_r      <= 1'b1;
            c_r      <= 1'b0;
            v_r      <= 1'b0;
            done_r   <= 1'b0;
`ifdef ALU_MUL_EN
            busy_r   <= 1'b0;
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {SHIFT_W{1'b0}};
`endif
        end else begin
            state_r  <= state_s;
            b_r      <= b_s;
            y_r      <= y_s;
            n_r      <= n_s;
            z_r      <= z_s;
            c_r      <= c_s;
            v_r      <= v_s;
            done_r   <= done_s;
`ifdef ALU_MUL_EN
            busy_r   <= busy_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
`endif
        end
    end

    assign o_y        = i_oe ? y_r : {WIDTH{1'bz}};
    assign o_done     = done_r;
    assign o_negative = n_r;
    assign o_zero     = z_r;
    assign o_carry    = c_r;
    assign o_overflow = v_r;

endmodule
